llc_input_sched: RTL and testbench
==================================

// Module: llc_input_sched
// PURPOSE
//  Parametrised front-end scheduler for the LLC pipeline. Buffers NUM_CH input channels
//  (rsp/rst/dma/req style), selects one per transaction, and issues it to the
//  READ_MEM/LOOKUP/PROCESS/UPDATE pipeline. Holds that transaction until the pipeline
//  reports completion. Generalises the fixed 4-input decode stage with:
//  - N channels;
//  - fixed-priority or round-robin selection;
//  - a one-entry stall/replay slot.
// PARAMETERS
//  NUM_CH    4   number of input channels; ch0 has highest fixed priority
//  PLD_W     64  payload width per channel (opaque message bits)
//  SET_W     9   LLC set-index width carried with each payload
//  RR_MODE   0   0 = fixed priority; 1 = round-robin starting after the last grant
//  STALL_CH  3   only channel whose transactions can be stalled/replayed (req channel)
// PORTS
//  clk          in   1               clock
//  rst          in   1               async reset, active low
//  in_valid     in   NUM_CH          per-channel valid
//  in_ready     out  NUM_CH          per-channel ready
//  in_pld       in   NUM_CH*PLD_W    per-channel payload, channel i at [i*PLD_W +: PLD_W]
//  in_set       in   NUM_CH*SET_W    per-channel set index
//  iss_valid    out  1               transaction offered to pipeline
//  iss_ready    in   1               pipeline accepts
//  iss_ch       out  $clog2(NUM_CH)  source channel of issued transaction
//  iss_pld      out  PLD_W           issued payload
//  iss_set      out  SET_W           issued set
//  iss_replay   out  1               issued transaction comes from the stall slot
//  op_done      in   1               pipeline finished the in-flight transaction (1-cycle pulse)
//  op_stall     in   1               qualifies op_done: park the transaction in the stall slot
//  stall_clr    in   1               pulse: stalled transaction may be replayed
//  stalled      out  1               stall slot occupied
// BEHAVIOUR
//  Reset (rst=0, async):
//  - all skid buffers empty, stall slot empty, FSM=IDLE, RR pointer=0;
//  - in_ready=0, iss_valid=0, iss_* = 0, stalled=0.
//  Input buffers:
//  - one skid entry per channel; in_ready[i] = !buf_full[i];
//  - capture on in_valid&in_ready; entry freed when its transaction is issued
//    (iss_valid&iss_ready).
//  FSM:
//  - IDLE: pick a candidate. If there is a candidate, register the pick, set
//    iss_valid=1 next cycle, go to ISSUE.
//  - ISSUE: hold iss_* stable while iss_ready=0. On iss_ready, go to WAIT and free
//    the source buffer.
//  - WAIT: on op_done&!op_stall, go to IDLE.
//    On op_done&op_stall: copy the transaction into the stall slot, stalled=1, go to IDLE.
//    op_stall is legal only when iss_ch==STALL_CH; otherwise it is ignored (treated as
//    done).
//  Candidate rules, in decreasing precedence:
//  - 1) stall slot if occupied and released (stall_clr seen), iss_replay=1;
//  - 2) buffered channels per RR_MODE; channel STALL_CH is masked while stalled=1.
//  - RR_MODE=1: the pointer advances to grant+1 (mod NUM_CH) on each non-replay issue.
//  Stall slot:
//  - stall_clr latches a release flag.
//  - stall_clr arriving in the same cycle as op_done&op_stall applies to the newly
//    parked entry (replay allowed immediately).
//  - Slot and release flag are cleared when the replay is accepted.
//  Latency:
//  - input captured at edge N -> earliest iss_valid after edge N+1 (2-cycle min);
//  - one transaction in flight at a time.
//  Simultaneity:
//  - capture and free of the same buffer in one cycle is legal; the buffer stays full.
//  - op_done in ISSUE is ignored.
//  Reset mid-operation:
//  - all state is dropped immediately; the in-flight transaction and the stalled
//    transaction are lost.
// TESTING
//  - Reset: rst=0 with in_valid=4'hF -> in_ready=0, iss_valid=0; rst=1 -> in_ready=4'hF next cycle.
//  - Fixed priority (RR_MODE=0): ch1,ch3 valid together, op_done after each ->
//    iss_ch=1 then 3; iss_valid rises 2 cycles after capture.
//  - Round-robin (RR_MODE=1): all 4 channels kept full -> grant order 0,1,2,3,0;
//    no channel starves.
//  - Stall: ch3 pld=64'hA5 issued, op_done&op_stall -> stalled=1. A new ch3 entry is
//    held while ch0 still issues. stall_clr -> next issue is pld 64'hA5 with iss_replay=1.
//  - Backpressure: iss_ready=0 for 5 cycles -> iss_pld/iss_ch stable; the source buffer
//    stays full, in_ready[i]=0.
//  - Corners:
//    - stall_clr coincident with op_stall -> replay on the next IDLE;
//    - op_stall on ch0 -> ignored, stalled stays 0.

Source files
------------

// File: rtl/llc_input_sched.sv
// LLC front-end scheduler: per-channel skid buffers, fixed-priority or round-robin
// pick, one transaction in flight, and a single stall/replay slot for STALL_CH.
module llc_input_sched #(
    parameter int unsigned NUM_CH   = 4,
    parameter int unsigned PLD_W    = 64,
    parameter int unsigned SET_W    = 9,
    parameter int unsigned RR_MODE  = 0,
    parameter int unsigned STALL_CH = 3,
    localparam int unsigned CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH*PLD_W-1:0]   in_pld,
    input  logic [NUM_CH*SET_W-1:0]   in_set,
    output logic                      iss_valid,
    input  logic                      iss_ready,
    output logic [CH_W-1:0]           iss_ch,
    output logic [PLD_W-1:0]          iss_pld,
    output logic [SET_W-1:0]          iss_set,
    output logic                      iss_replay,
    input  logic                      op_done,
    input  logic                      op_stall,
    input  logic                      stall_clr,
    output logic                      stalled
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_t;

    state_t             state;
    logic               active;
    logic [NUM_CH-1:0]  buf_full;
    logic [PLD_W-1:0]   buf_pld [NUM_CH];
    logic [SET_W-1:0]   buf_set [NUM_CH];

    logic               slot_full;
    logic               slot_rel;
    logic [PLD_W-1:0]   slot_pld;
    logic [SET_W-1:0]   slot_set;
    logic [CH_W-1:0]    rr_ptr;

    logic               accept;
    logic [NUM_CH-1:0]  cap;
    logic [NUM_CH-1:0]  free;
    logic [NUM_CH-1:0]  elig;
    logic               pick_any;
    logic [CH_W-1:0]    pick_ch;
    logic [CH_W-1:0]    cand;

    // in_ready stays low until the first clock after reset release
    assign in_ready = {NUM_CH{active}} & ~buf_full;
    assign accept   = iss_valid & iss_ready;
    assign stalled  = slot_full;

    always_comb begin
        cap  = '0;
        free = '0;
        elig = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            cap[i]  = in_valid[i] & in_ready[i];
            free[i] = accept & ~iss_replay & (iss_ch == CH_W'(i));
            elig[i] = buf_full[i] & ~(slot_full & (i == STALL_CH));
        end
    end

    // RR scans from rr_ptr upward; fixed priority scans from ch0
    always_comb begin
        pick_any = 1'b0;
        pick_ch  = '0;
        cand     = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            cand = (RR_MODE != 0) ? CH_W'((32'(rr_ptr) + k) % NUM_CH) : CH_W'(k);
            if (!pick_any && elig[cand]) begin
                pick_any = 1'b1;
                pick_ch  = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full <= '0;
        end else begin
            buf_full <= (buf_full & ~free) | cap;
        end
    end

    always_ff @(posedge clk) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (cap[i]) begin
                buf_pld[i] <= in_pld[i*PLD_W +: PLD_W];
                buf_set[i] <= in_set[i*SET_W +: SET_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_IDLE;
            active     <= 1'b0;
            iss_valid  <= 1'b0;
            iss_ch     <= '0;
            iss_pld    <= '0;
            iss_set    <= '0;
            iss_replay <= 1'b0;
            slot_full  <= 1'b0;
            slot_rel   <= 1'b0;
            slot_pld   <= '0;
            slot_set   <= '0;
            rr_ptr     <= '0;
        end else begin
            active <= 1'b1;
            if (stall_clr && slot_full) begin
                slot_rel <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (slot_full && slot_rel) begin
                        iss_valid  <= 1'b1;
                        iss_ch     <= CH_W'(STALL_CH);
                        iss_pld    <= slot_pld;
                        iss_set    <= slot_set;
                        iss_replay <= 1'b1;
                        state      <= ST_ISSUE;
                    end else if (pick_any) begin
                        iss_valid  <= 1'b1;
                        iss_ch     <= pick_ch;
                        iss_pld    <= buf_pld[pick_ch];
                        iss_set    <= buf_set[pick_ch];
                        iss_replay <= 1'b0;
                        state      <= ST_ISSUE;
                        if (RR_MODE != 0) begin
                            rr_ptr <= (pick_ch == CH_W'(NUM_CH - 1)) ? '0 : pick_ch + 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (iss_ready) begin
                        iss_valid <= 1'b0;
                        state     <= ST_WAIT;
                        if (iss_replay) begin
                            slot_full <= 1'b0;
                            slot_rel  <= 1'b0;
                        end
                    end
                end
                ST_WAIT: begin
                    if (op_done) begin
                        state <= ST_IDLE;
                        // a stall_clr in the parking cycle releases the new entry at once
                        if (op_stall && (iss_ch == CH_W'(STALL_CH))) begin
                            slot_full <= 1'b1;
                            slot_pld  <= iss_pld;
                            slot_set  <= iss_set;
                            slot_rel  <= stall_clr;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_llc_input_sched.sv
// Bench for llc_input_sched: a fixed-priority and a round-robin instance share stimulus
// and are checked every cycle against a transaction-level model, plus directed scenarios.
module tb_llc_input_sched;

    localparam int NCH = 4;
    localparam int PW  = 64;
    localparam int SW  = 9;
    localparam int SCH = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic [NCH-1:0]   in_valid;
    logic [NCH*PW-1:0] in_pld;
    logic [NCH*SW-1:0] in_set;
    logic             iss_ready;
    logic             op_done;
    logic             op_stall;
    logic             stall_clr;

    logic [NCH-1:0]   in_ready   [2];
    logic             iss_valid  [2];
    logic [1:0]       iss_ch     [2];
    logic [PW-1:0]    iss_pld    [2];
    logic [SW-1:0]    iss_set    [2];
    logic             iss_replay [2];
    logic             stalled    [2];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    llc_input_sched #(.NUM_CH(NCH), .PLD_W(PW), .SET_W(SW), .RR_MODE(0), .STALL_CH(SCH)) dut_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_pld(in_pld), .in_set(in_set), .iss_valid(iss_valid[0]), .iss_ready(iss_ready),
        .iss_ch(iss_ch[0]), .iss_pld(iss_pld[0]), .iss_set(iss_set[0]),
        .iss_replay(iss_replay[0]), .op_done(op_done), .op_stall(op_stall),
        .stall_clr(stall_clr), .stalled(stalled[0])
    );

    llc_input_sched #(.NUM_CH(NCH), .PLD_W(PW), .SET_W(SW), .RR_MODE(1), .STALL_CH(SCH)) dut_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_pld(in_pld), .in_set(in_set), .iss_valid(iss_valid[1]), .iss_ready(iss_ready),
        .iss_ch(iss_ch[1]), .iss_pld(iss_pld[1]), .iss_set(iss_set[1]),
        .iss_replay(iss_replay[1]), .op_done(op_done), .op_stall(op_stall),
        .stall_clr(stall_clr), .stalled(stalled[1])
    );

    // Reference model: d=0 fixed priority, d=1 round-robin
    bit            m_act   [2];
    bit            m_full  [2][NCH];
    logic [PW-1:0] m_bpld  [2][NCH];
    logic [SW-1:0] m_bset  [2][NCH];
    bit            m_offer [2];   // transaction offered, not yet accepted
    bit            m_busy  [2];   // transaction accepted, pipeline still working
    int            m_och   [2];
    logic [PW-1:0] m_opld  [2];
    logic [SW-1:0] m_oset  [2];
    bit            m_orep  [2];
    bit            m_sfull [2];
    bit            m_srel  [2];
    logic [PW-1:0] m_spld  [2];
    logic [SW-1:0] m_sset  [2];
    int            m_ptr   [2];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset(input int d);
        m_act[d] = 0; m_offer[d] = 0; m_busy[d] = 0; m_och[d] = 0;
        m_opld[d] = '0; m_oset[d] = '0; m_orep[d] = 0;
        m_sfull[d] = 0; m_srel[d] = 0; m_spld[d] = '0; m_sset[d] = '0; m_ptr[d] = 0;
        for (int c = 0; c < NCH; c++) m_full[d][c] = 0;
    endtask

    task automatic step_model();
        for (int d = 0; d < 2; d++) begin
            bit acc, sf, sr;
            bit [NCH-1:0] capv, freev;
            int pick;
            if (!rst) begin
                model_reset(d);
            end else begin
                acc = m_offer[d] && iss_ready;
                sf  = m_sfull[d];
                sr  = m_srel[d];
                for (int c = 0; c < NCH; c++) begin
                    capv[c]  = in_valid[c] && m_act[d] && !m_full[d][c];
                    freev[c] = acc && !m_orep[d] && (m_och[d] == c);
                end
                if (stall_clr && sf) m_srel[d] = 1;
                if (m_offer[d]) begin
                    if (acc) begin
                        m_offer[d] = 0;
                        m_busy[d]  = 1;
                        if (m_orep[d]) begin m_sfull[d] = 0; m_srel[d] = 0; end
                    end
                end else if (m_busy[d]) begin
                    if (op_done) begin
                        m_busy[d] = 0;
                        if (op_stall && m_och[d] == SCH) begin
                            m_sfull[d] = 1; m_spld[d] = m_opld[d]; m_sset[d] = m_oset[d];
                            m_srel[d]  = stall_clr;
                        end
                    end
                end else if (sf && sr) begin
                    m_offer[d] = 1; m_och[d] = SCH; m_orep[d] = 1;
                    m_opld[d] = m_spld[d]; m_oset[d] = m_sset[d];
                end else begin
                    pick = -1;
                    for (int k = 0; k < NCH; k++) begin
                        int c;
                        c = (d == 1) ? (m_ptr[d] + k) % NCH : k;
                        if (pick < 0 && m_full[d][c] && !(sf && c == SCH)) pick = c;
                    end
                    if (pick >= 0) begin
                        m_offer[d] = 1; m_och[d] = pick; m_orep[d] = 0;
                        m_opld[d] = m_bpld[d][pick]; m_oset[d] = m_bset[d][pick];
                        if (d == 1) m_ptr[d] = (pick + 1) % NCH;
                    end
                end
                for (int c = 0; c < NCH; c++) begin
                    if (capv[c]) begin
                        m_full[d][c] = 1;
                        m_bpld[d][c] = in_pld[c*PW +: PW];
                        m_bset[d][c] = in_set[c*SW +: SW];
                    end else if (freev[c]) begin
                        m_full[d][c] = 0;
                    end
                end
                m_act[d] = 1;
            end
        end
    endtask

    task automatic compare_all();
        for (int d = 0; d < 2; d++) begin
            logic [NCH-1:0] r;
            for (int c = 0; c < NCH; c++) r[c] = m_act[d] && !m_full[d][c];
            check_eq($sformatf("d%0d.in_ready", d), 64'(in_ready[d]), 64'(r));
            check_eq($sformatf("d%0d.iss_valid", d), 64'(iss_valid[d]), 64'(m_offer[d]));
            check_eq($sformatf("d%0d.iss_ch", d), 64'(iss_ch[d]), 64'(m_och[d]));
            check_eq($sformatf("d%0d.iss_pld", d), iss_pld[d], m_opld[d]);
            check_eq($sformatf("d%0d.iss_set", d), 64'(iss_set[d]), 64'(m_oset[d]));
            check_eq($sformatf("d%0d.iss_replay", d), 64'(iss_replay[d]), 64'(m_orep[d]));
            check_eq($sformatf("d%0d.stalled", d), 64'(stalled[d]), 64'(m_sfull[d]));
        end
    endtask

    task automatic tick();
        step_model();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        in_valid = '0; iss_ready = 0; op_done = 0; op_stall = 0; stall_clr = 0;
    endtask

    task automatic do_reset();
        rst = 0;
        clear_inputs();
        model_reset(0);
        model_reset(1);
        tick();
        rst = 1;
        tick();
    endtask

    task automatic wait_valid(input int d, input int budget);
        int n;
        n = 0;
        while (!iss_valid[d] && n < budget) begin
            tick();
            n++;
        end
        check_eq($sformatf("d%0d.wait_valid", d), 64'(iss_valid[d]), 64'd1);
    endtask

    task automatic accept_and_done(input bit stall);
        iss_ready = 1;
        tick();
        iss_ready = 0;
        op_done = 1;
        op_stall = stall;
        tick();
        op_done = 0;
        op_stall = 0;
    endtask

    function automatic logic [NCH*PW-1:0] rand_pld();
        logic [NCH*PW-1:0] v;
        for (int i = 0; i < NCH*PW/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [NCH*SW-1:0] rand_set();
        logic [63:0] t;
        t = {$urandom, $urandom};
        return t[NCH*SW-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [PW-1:0] bp_val;
        int rr_exp [5];

        rst = 1;
        clear_inputs();
        in_pld = '0;
        in_set = '0;
        #2;
        // Reset with all channels valid
        rst = 0;
        in_valid = 4'hF;
        model_reset(0);
        model_reset(1);
        #1;
        compare_all();
        check_eq("rst_in_ready", 64'(in_ready[0]), 64'h0);
        check_eq("rst_iss_valid", 64'(iss_valid[0]), 64'h0);
        tick();
        rst = 1;
        in_valid = '0;
        tick();
        check_eq("rst_release_in_ready", 64'(in_ready[0]), 64'hF);

        // Fixed priority: ch1 and ch3 together
        in_pld = '0;
        in_pld[1*PW +: PW] = 64'h1111;
        in_pld[3*PW +: PW] = 64'h3333;
        in_set = rand_set();
        in_valid = 4'b1010;
        tick();
        in_valid = '0;
        check_eq("fp_no_issue_at_capture", 64'(iss_valid[0]), 64'h0);
        check_eq("fp_captured", 64'(in_ready[0]), 64'h5);
        tick();
        check_eq("fp_first_valid", 64'(iss_valid[0]), 64'h1);
        check_eq("fp_first_ch", 64'(iss_ch[0]), 64'h1);
        check_eq("fp_first_pld", iss_pld[0], 64'h1111);
        accept_and_done(0);
        wait_valid(0, 8);
        check_eq("fp_second_ch", 64'(iss_ch[0]), 64'h3);
        check_eq("fp_second_pld", iss_pld[0], 64'h3333);
        accept_and_done(0);

        // Round-robin with all channels kept full
        do_reset();
        rr_exp = '{0, 1, 2, 3, 0};
        in_pld = rand_pld();
        in_set = rand_set();
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            wait_valid(1, 10);
            check_eq($sformatf("rr_grant%0d", i), 64'(iss_ch[1]), 64'(rr_exp[i]));
            accept_and_done(0);
        end
        in_valid = '0;

        // Stall and replay on the req channel
        do_reset();
        in_pld = '0;
        in_pld[3*PW +: PW] = 64'hA5;
        in_valid = 4'b1000;
        tick();
        in_valid = '0;
        wait_valid(0, 5);
        check_eq("st_first_ch", 64'(iss_ch[0]), 64'h3);
        check_eq("st_first_pld", iss_pld[0], 64'hA5);
        accept_and_done(1);
        check_eq("st_stalled", 64'(stalled[0]), 64'h1);
        in_pld[0*PW +: PW] = 64'hC0;
        in_pld[3*PW +: PW] = 64'hB6;
        in_valid = 4'b1001;
        tick();
        in_valid = '0;
        wait_valid(0, 5);
        check_eq("st_ch0_passes", 64'(iss_ch[0]), 64'h0);
        accept_and_done(0);
        repeat (4) tick();
        check_eq("st_ch3_held", 64'(iss_valid[0]), 64'h0);
        check_eq("st_ch3_buf_full", 64'(in_ready[0]), 64'h7);
        stall_clr = 1;
        tick();
        stall_clr = 0;
        wait_valid(0, 5);
        check_eq("st_replay_flag", 64'(iss_replay[0]), 64'h1);
        check_eq("st_replay_pld", iss_pld[0], 64'hA5);
        check_eq("st_replay_ch", 64'(iss_ch[0]), 64'h3);
        accept_and_done(0);
        check_eq("st_slot_freed", 64'(stalled[0]), 64'h0);
        wait_valid(0, 5);
        check_eq("st_new_pld", iss_pld[0], 64'hB6);
        check_eq("st_new_replay", 64'(iss_replay[0]), 64'h0);
        accept_and_done(0);

        // Backpressure holds the offer and the source buffer
        do_reset();
        bp_val = {$urandom, $urandom};
        in_pld = rand_pld();
        in_pld[2*PW +: PW] = bp_val;
        in_valid = 4'b0100;
        tick();
        in_valid = '0;
        wait_valid(0, 5);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("bp_pld", iss_pld[0], bp_val);
            check_eq("bp_ch", 64'(iss_ch[0]), 64'h2);
            check_eq("bp_in_ready", 64'(in_ready[0]), 64'hB);
        end
        accept_and_done(0);
        check_eq("bp_freed", 64'(in_ready[0]), 64'hF);

        // stall_clr coincident with parking
        do_reset();
        in_pld[3*PW +: PW] = 64'h77;
        in_valid = 4'b1000;
        tick();
        in_valid = '0;
        wait_valid(0, 5);
        iss_ready = 1;
        tick();
        iss_ready = 0;
        op_done = 1; op_stall = 1; stall_clr = 1;
        tick();
        op_done = 0; op_stall = 0; stall_clr = 0;
        check_eq("co_stalled", 64'(stalled[0]), 64'h1);
        tick();
        check_eq("co_replay_valid", 64'(iss_valid[0]), 64'h1);
        check_eq("co_replay_flag", 64'(iss_replay[0]), 64'h1);
        check_eq("co_replay_pld", iss_pld[0], 64'h77);
        accept_and_done(0);

        // op_stall on a non-stall channel is treated as done
        do_reset();
        in_valid = 4'b0001;
        tick();
        in_valid = '0;
        wait_valid(0, 5);
        accept_and_done(1);
        check_eq("ch0_stall_ignored", 64'(stalled[0]), 64'h0);

        // Randomized traffic with occasional mid-operation resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            in_valid  = 4'($urandom);
            in_pld    = rand_pld();
            in_set    = rand_set();
            iss_ready = 1'($urandom_range(0, 1));
            op_done   = ($urandom_range(0, 3) == 0);
            op_stall  = 1'($urandom_range(0, 1));
            stall_clr = ($urandom_range(0, 7) == 0);
            rst       = ($urandom_range(0, 499) != 0);
            tick();
        end
        rst = 1;
        clear_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
